// File: rtl/loom_clk_ctrl.sv
// Run/stop/step controller driving the clock-gate enable.
// ce_o is a flop output so the gate never sees a combinational glitch.
module loom_clk_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic             stop_req_i,
    output logic             ce_o,
    output logic             running_o,
    output logic             done_o,
    output logic [1:0]       stop_cause_o,
    output logic [63:0]      cycle_count_o
);
    localparam logic [1:0] OP_STOP = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_CLR = 2'd3;
    localparam logic [1:0] C_HOST = 2'd1, C_STEP = 2'd2, C_BREAK = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic               stop_evt;
    logic [1:0]         cause_nxt;
    logic               ce_nxt;
    logic               clr;
    logic [63:0]        count_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            remaining     <= '0;
            ce_o          <= 1'b0;
            done_o        <= 1'b0;
            stop_cause_o  <= 2'd0;
            cycle_count_o <= '0;
            cmd_ready_o   <= 1'b0;
        end else begin
            state         <= state_nxt;
            remaining     <= remaining_nxt;
            ce_o          <= ce_nxt;
            done_o        <= stop_evt;
            stop_cause_o  <= cause_nxt;
            cycle_count_o <= count_nxt;
            cmd_ready_o   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        stop_evt      = 1'b0;
        cause_nxt     = stop_cause_o;
        case (state)
            S_IDLE: begin
                // STOP and breakpoints are meaningless while already stopped
                if (cmd_valid_i && cmd_op_i == OP_RUN) begin
                    state_nxt = S_RUN;
                end else if (cmd_valid_i && cmd_op_i == OP_STEP) begin
                    if (cmd_count_i != '0) begin
                        state_nxt     = S_STEP;
                        remaining_nxt = cmd_count_i;
                    end else begin
                        stop_evt  = 1'b1;
                        cause_nxt = C_STEP;
                    end
                end
            end
            S_RUN, S_STEP: begin
                // breakpoint beats host command, which beats step expiry
                if (stop_req_i) begin
                    state_nxt = S_IDLE;
                    stop_evt  = 1'b1;
                    cause_nxt = C_BREAK;
                end else if (cmd_valid_i && cmd_op_i != OP_CLR) begin
                    case (cmd_op_i)
                        OP_STOP: begin
                            state_nxt = S_IDLE;
                            stop_evt  = 1'b1;
                            cause_nxt = C_HOST;
                        end
                        OP_RUN: state_nxt = S_RUN;
                        default: begin
                            if (cmd_count_i != '0) begin
                                state_nxt     = S_STEP;
                                remaining_nxt = cmd_count_i;
                            end else begin
                                state_nxt = S_IDLE;
                                stop_evt  = 1'b1;
                                cause_nxt = C_STEP;
                            end
                        end
                    endcase
                end else if (state == S_STEP) begin
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = S_IDLE;
                        stop_evt  = 1'b1;
                        cause_nxt = C_STEP;
                    end
                    remaining_nxt = remaining - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ce_nxt    = (state_nxt != S_IDLE);
        clr       = cmd_valid_i && (cmd_op_i == OP_CLR);
        count_nxt = clr ? 64'd0 : cycle_count_o + {63'd0, ce_o};
    end

    assign running_o = ce_o;

endmodule

// File: tb/tb_loom_clk_ctrl.sv
// Scoreboard bench for loom_clk_ctrl: each scenario queues stimulus with the
// expected post-edge outputs, then replays and compares cycle by cycle.
module tb_loom_clk_ctrl;
    localparam logic [1:0] OP_STOP = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_CLR = 2'd3;

    typedef struct { logic v; logic [1:0] op; logic [31:0] n; logic s; } stim_t;
    typedef struct { logic ce; logic done; logic [1:0] cause; logic [63:0] cnt; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_count = '0;
    logic        stop_req = 1'b0;
    logic        ce, running, done;
    logic [1:0]  stop_cause;
    logic [63:0] cycle_count;

    int n_chk = 0;
    int n_fail = 0;
    stim_t sq[$];
    exp_t  eq[$];

    always #5 clk = ~clk;

    loom_clk_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_count_i(cmd_count), .stop_req_i(stop_req),
        .ce_o(ce), .running_o(running), .done_o(done),
        .stop_cause_o(stop_cause), .cycle_count_o(cycle_count)
    );

    function automatic void add(input logic v, input logic [1:0] op, input int n, input logic s,
                                input logic xce, input logic xdone, input logic [1:0] xcause,
                                input longint xcnt);
        sq.push_back('{v, op, 32'(n), s});
        eq.push_back('{xce, xdone, xcause, 64'(xcnt)});
    endfunction

    task automatic drive(input stim_t s);
        cmd_valid = s.v; cmd_op = s.op; cmd_count = s.n; stop_req = s.s;
        @(posedge clk); #1;
        cmd_valid = 1'b0; stop_req = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 n_chk++;
        if ({cmd_ready, ce, done, stop_cause, cycle_count} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_async: ready=%b ce=%b done=%b cause=%0d cnt=%0d, want all 0",
                     cmd_ready, ce, done, stop_cause, cycle_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive('{1'b0, OP_STOP, 32'd0, 1'b0});
        n_chk++;
        if ({cmd_ready, ce, running, done, stop_cause} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b ce=%b run=%b done=%b cause=%0d, want ready=1 rest 0",
                     cmd_ready, ce, running, done, stop_cause);
        end
    endtask

    task automatic test_step();
        stim_t s; exp_t e; int i;
        for (int k = 0; k < 9; k++) add(0, OP_STOP, 0, 0, 0, 0, 0, 0);
        add(1, OP_STEP, 5, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, OP_STOP, 0, 0, 1, 0, 0, k);
        add(0, OP_STOP, 0, 0, 0, 1, 2, 5);
        add(0, OP_STOP, 0, 0, 0, 0, 2, 5);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL step5[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_run_stop();
        stim_t s; exp_t e; int i;
        add(1, OP_CLR, 0, 0, 0, 0, 2, 0);
        add(1, OP_RUN, 0, 0, 1, 0, 2, 0);
        for (int k = 1; k <= 19; k++) add(0, OP_STOP, 0, 0, 1, 0, 2, k);
        add(1, OP_STOP, 0, 0, 0, 1, 1, 20);
        add(0, OP_STOP, 0, 0, 0, 0, 1, 20);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL run_stop[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_break();
        stim_t s; exp_t e; int i;
        add(1, OP_CLR, 0, 0, 0, 0, 1, 0);
        add(1, OP_RUN, 0, 0, 1, 0, 1, 0);
        for (int k = 1; k <= 7; k++) add(0, OP_STOP, 0, 0, 1, 0, 1, k);
        add(1, OP_STOP, 0, 1, 0, 1, 3, 8);
        add(0, OP_STOP, 0, 1, 0, 0, 3, 8);
        add(0, OP_STOP, 0, 0, 0, 0, 3, 8);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL break[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_step_run();
        stim_t s; exp_t e; int i;
        add(1, OP_CLR, 0, 0, 0, 0, 3, 0);
        add(1, OP_STEP, 3, 0, 1, 0, 3, 0);
        add(0, OP_STOP, 0, 0, 1, 0, 3, 1);
        add(0, OP_STOP, 0, 0, 1, 0, 3, 2);
        add(1, OP_RUN, 0, 0, 1, 0, 3, 3);
        add(0, OP_STOP, 0, 0, 1, 0, 3, 4);
        add(1, OP_STOP, 0, 0, 0, 1, 1, 5);
        add(0, OP_STOP, 0, 0, 0, 0, 1, 5);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL step_run[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_step_zero();
        stim_t s; exp_t e; int i;
        add(1, OP_CLR, 0, 0, 0, 0, 1, 0);
        add(1, OP_STEP, 0, 0, 0, 1, 2, 0);
        add(0, OP_STOP, 0, 0, 0, 0, 2, 0);
        add(1, OP_STOP, 0, 0, 0, 0, 2, 0);
        add(0, OP_STOP, 0, 1, 0, 0, 2, 0);
        add(0, OP_STOP, 0, 0, 0, 0, 2, 0);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL step_zero[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; exp_t e; int i;
        add(1, OP_STEP, 2, 0, 1, 0, 2, 0);
        add(1, OP_STEP, 3, 0, 1, 0, 2, 1);
        add(1, OP_CLR, 0, 0, 1, 0, 2, 0);
        add(0, OP_STOP, 0, 0, 1, 0, 2, 1);
        add(0, OP_STOP, 0, 0, 0, 1, 2, 2);
        add(1, OP_STEP, 1, 0, 1, 0, 2, 2);
        add(0, OP_STOP, 0, 0, 0, 1, 2, 3);
        add(0, OP_STOP, 0, 0, 0, 0, 2, 3);
        add(1, OP_STEP, 4, 0, 1, 0, 2, 3);
        add(1, OP_CLR, 0, 1, 0, 1, 3, 0);
        add(0, OP_STOP, 0, 0, 0, 0, 3, 0);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_clr_reset();
        stim_t s; exp_t e; int i;
        add(1, OP_RUN, 0, 0, 1, 0, 3, 0);
        for (int k = 1; k <= 100; k++) add(0, OP_STOP, 0, 0, 1, 0, 3, k);
        add(1, OP_CLR, 0, 0, 1, 0, 3, 0);
        add(0, OP_STOP, 0, 0, 1, 0, 3, 1);
        add(1, OP_STEP, 10, 0, 1, 0, 3, 2);
        add(0, OP_STOP, 0, 0, 1, 0, 3, 3);
        add(0, OP_STOP, 0, 0, 1, 0, 3, 4);
        i = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front(); drive(s); e = eq.pop_front(); n_chk++;
            if ({ce, running, done, stop_cause, cycle_count} !== {e.ce, e.ce, e.done, e.cause, e.cnt}) begin
                n_fail++;
                $display("FAIL clr_count[%0d]: got ce=%b run=%b done=%b cause=%0d cnt=%0d want ce=%b done=%b cause=%0d cnt=%0d",
                         i, ce, running, done, stop_cause, cycle_count, e.ce, e.done, e.cause, e.cnt);
            end
            i++;
        end
        // reset lands mid-step, away from any clock edge
        #2 rst_n = 1'b0;
        #1 n_chk++;
        if ({ce, running, done, stop_cause, cycle_count, cmd_ready} !== 70'd0) begin
            n_fail++;
            $display("FAIL mid_step_reset: ce=%b run=%b done=%b cause=%0d cnt=%0d ready=%b, want all 0",
                     ce, running, done, stop_cause, cycle_count, cmd_ready);
        end
        #1 rst_n = 1'b1;
        drive('{1'b0, OP_STOP, 32'd0, 1'b0});
        n_chk++;
        if ({ce, done, stop_cause, cycle_count, cmd_ready} !== 69'd1) begin
            n_fail++;
            $display("FAIL post_reset: ce=%b done=%b cause=%0d cnt=%0d ready=%b, want ready=1 rest 0",
                     ce, done, stop_cause, cycle_count, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_stop();
        test_break();
        test_step_run();
        test_step_zero();
        test_back_to_back();
        test_clr_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/loom_clk_ctrl.md
Name: loom_clk_ctrl

Overview:
Run/stop/step controller that generates the clock-enable for the DUT clock gate. The gate takes ce=1 to run and ce=0 to stop.
- Accepts host commands over a valid/ready interface: RUN, STOP, STEP N, CLR_COUNT.
- Honours a synchronous stop request from DUT breakpoint logic.
- Counts enabled cycles and reports why the clock stopped.
- Sits between the host register file and the gate cell; ce_o feeds the gate's ce input directly.

Parameters:
CNT_W, 32, width of the STEP count and of the remaining-cycle counter.

Ports:
clk_i  input  1  free-running clock (ungated side of the gate).
rst_ni  input  1  asynchronous active-low reset.
cmd_valid_i  input  1  host command valid.
cmd_ready_o  output  1  always 1 outside reset; every command is accepted in the cycle it is valid.
cmd_op_i  input  2  0=STOP, 1=RUN, 2=STEP, 3=CLR_COUNT.
cmd_count_i  input  CNT_W  number of cycles for STEP; ignored for other ops.
stop_req_i  input  1  synchronous breakpoint/trap stop request, level or pulse.
ce_o  output  1  registered clock enable to the gate.
running_o  output  1  equals ce_o.
done_o  output  1  one-cycle pulse when the clock stops, or when STEP 0 completes.
stop_cause_o  output  2  last stop cause: 0=NONE, 1=HOST, 2=STEP, 3=BREAK.
cycle_count_o  output  64  number of cycles with ce_o=1; wraps at 2^64.

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE; ce_o=0, done_o=0, stop_cause_o=0, cycle_count_o=0, remaining=0.
  - cmd_ready_o=0 while in reset, 1 after.
  - Reset mid-RUN or mid-STEP drops ce_o immediately (asynchronously) with no done_o pulse.
- States:
  - IDLE: ce_o=0.
  - RUN: ce_o=1.
  - STEP: ce_o=1, remaining counts down.
- Timing: all outputs are registered. A command accepted at edge t takes effect on ce_o from cycle t+1.
- IDLE transitions:
  - RUN -> RUN.
  - STEP N with N>0 -> STEP with remaining=N.
  - STEP 0 -> stays IDLE; done_o=1 and stop_cause_o=STEP at t+1.
  - STOP -> no-op; no done_o.
  - stop_req_i -> ignored.
- RUN transitions:
  - STOP -> IDLE, cause HOST.
  - RUN -> no change.
  - STEP N with N>0 -> STEP with remaining=N.
  - STEP 0 -> IDLE, cause STEP.
- STEP:
  - STEP N produces exactly N consecutive cycles with ce_o=1.
  - remaining decrements every STEP cycle. When remaining==1, next state is IDLE with cause STEP.
  - RUN in STEP -> RUN, with no done_o.
  - STOP in STEP -> IDLE, cause HOST.
  - A new STEP M reloads remaining=M; the current cycle counts as the last cycle of the old step.
- Priority when events coincide in RUN/STEP, highest first:
  1. stop_req_i: next state IDLE, cause BREAK. A simultaneous command is consumed and discarded, except CLR_COUNT, which still applies.
  2. Host command.
  3. STEP expiry. A host RUN on the last step cycle suppresses the stop; a host STOP on the last step cycle gives cause HOST.
- On every transition RUN/STEP -> IDLE:
  - ce_o=0 and done_o=1 in the same cycle.
  - stop_cause_o updates in that cycle and holds until the next stop.
  - Entering RUN or STEP does not clear stop_cause_o.
- cycle_count_o:
  - Increments by 1 in each cycle where ce_o=1.
  - CLR_COUNT sets it to 0 at the next edge, overriding that cycle's increment. It does not change state or ce_o.
  - Wraps from all-ones to 0.
- ce_o is glitch-free by construction: a flop output only, no combinational path from inputs.

Test Plan:
1. Reset, then STEP 5 accepted at cycle 10 -> ce_o=1 for cycles 11..15 exactly; ce_o=0 and done_o=1 at cycle 16; stop_cause_o=2; cycle_count_o=5.
2. RUN at cycle 0, STOP at cycle 20 -> ce_o=1 for cycles 1..20, 0 from cycle 21; done_o pulse at 21; cause=1; count=20.
3. RUN, then stop_req_i and a STOP command asserted together at cycle 8 -> IDLE at 9; cause=3 (BREAK wins); exactly one done_o pulse.
4. STEP 3 with RUN issued on the last step cycle -> no done_o; ce_o stays 1 continuously; a later STOP gives cause=1.
5. STEP 0 in IDLE -> ce_o never rises; done_o pulses once; cause=2. STOP in IDLE -> no done_o.
6. In RUN with count at 100, CLR_COUNT -> count=0 next cycle, then increments to 1. rst_ni driven low mid-STEP -> ce_o=0 immediately, count=0, no done_o pulse.
